// File: rtl/pwm_generator_pkg.sv
// Shared definitions for the PWM generator and its angle-to-PWM handshake partner.
package pwm_generator_pkg;

    localparam int unsigned PWM_CNT_W  = 8;
    localparam int unsigned PWM_PERIOD = 256;

    typedef enum logic [1:0] {
        GEN_OFF  = 2'd0,
        GEN_RUN  = 2'd1,
        GEN_DEAD = 2'd2
    } gen_state_e;

    // Command sampled from the controller at a period boundary; pwm_done acknowledges it.
    typedef struct packed {
        logic [PWM_CNT_W-1:0] ratio;
        logic                 direction;
    } pwm_cmd_t;

    // A command can be applied immediately unless it reverses a motor that is being driven.
    function automatic logic cmd_applies_now(input pwm_cmd_t             cmd,
                                             input logic                 cur_dir,
                                             input logic [PWM_CNT_W-1:0] cur_ratio);
        return (cmd.direction == cur_dir) || (cur_ratio == '0);
    endfunction

endpackage

// File: rtl/pwm_tick_gen.sv
// Prescaler and 8-bit PWM period counter; flags the last tick of each period.
module pwm_tick_gen
    import pwm_generator_pkg::*;
#(
    parameter int unsigned CLK_DIV = 10
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 clear,
    output logic                 tick,
    output logic [PWM_CNT_W-1:0] count,
    output logic                 boundary
);

    localparam int unsigned          PRE_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PRE_W-1:0]     PRE_MAX = PRE_W'(CLK_DIV - 1);
    localparam logic [PWM_CNT_W-1:0] CNT_MAX = PWM_CNT_W'(PWM_PERIOD - 1);

    logic [PRE_W-1:0]     pre_q;
    logic [PWM_CNT_W-1:0] cnt_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pre_q <= '0;
            cnt_q <= '0;
        end else if (clear) begin
            pre_q <= '0;
            cnt_q <= '0;
        end else begin
            pre_q <= tick ? '0 : pre_q + PRE_W'(1);
            if (tick) begin
                cnt_q <= cnt_q + PWM_CNT_W'(1);
            end
        end
    end

    assign tick     = (pre_q == PRE_MAX);
    assign count    = cnt_q;
    assign boundary = tick && (cnt_q == CNT_MAX);

endmodule

// File: rtl/pwm_generator.sv
// PWM output stage for one swerve rotation motor: boundary-aligned duty updates, pwm_done
// acknowledge, and forced-low dead-time on a direction reversal.
module pwm_generator
    import pwm_generator_pkg::*;
#(
    parameter int unsigned CLK_DIV          = 10,
    parameter int unsigned DEADTIME_PERIODS = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 pwm_enable,
    input  logic                 pwm_update,
    input  logic [PWM_CNT_W-1:0] pwm_ratio,
    input  logic                 pwm_direction,
    output logic                 pwm_done,
    output logic                 pwm_signal,
    output logic                 dir_out,
    output logic [1:0]           gen_state
);

    localparam int unsigned      DC_W      = $clog2(DEADTIME_PERIODS + 1);
    localparam logic [DC_W-1:0]  DEAD_LAST = DC_W'(DEADTIME_PERIODS - 1);

    gen_state_e           state_q, state_d;
    logic [PWM_CNT_W-1:0] ratio_q, ratio_d;
    logic                 dir_q, dir_d;
    logic [DC_W-1:0]      dead_q, dead_d;
    logic                 done_q, done_d;
    logic                 sig_q, sig_d;

    logic                 clear;
    logic                 unused_tick;
    logic [PWM_CNT_W-1:0] count;
    logic                 boundary;
    pwm_cmd_t             cmd;

    assign cmd   = '{ratio: pwm_ratio, direction: pwm_direction};
    assign clear = (state_q == GEN_OFF) || !pwm_enable;

    pwm_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_gen (
        .clock    (clock),
        .reset    (reset),
        .clear    (clear),
        .tick     (unused_tick),
        .count    (count),
        .boundary (boundary)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= GEN_OFF;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!pwm_enable) begin
            state_d = GEN_OFF;
        end else begin
            unique case (state_q)
                GEN_OFF:  state_d = GEN_RUN;
                GEN_RUN: begin
                    if (boundary && pwm_update && !cmd_applies_now(cmd, dir_q, ratio_q)) begin
                        state_d = GEN_DEAD;
                    end
                end
                GEN_DEAD: begin
                    if (boundary && (dead_q == DEAD_LAST)) begin
                        state_d = GEN_RUN;
                    end
                end
                default:  state_d = GEN_OFF;
            endcase
        end
    end

    always_comb begin
        ratio_d = ratio_q;
        dir_d   = dir_q;
        dead_d  = dead_q;
        done_d  = 1'b0;
        sig_d   = (state_q == GEN_RUN) && pwm_enable && (count < ratio_q);
        if (!pwm_enable) begin
            ratio_d = '0;
        end else begin
            unique case (state_q)
                GEN_OFF: begin
                    ratio_d = '0;
                    dead_d  = '0;
                end
                GEN_RUN: begin
                    if (boundary && pwm_update) begin
                        if (cmd_applies_now(cmd, dir_q, ratio_q)) begin
                            ratio_d = cmd.ratio;
                            dir_d   = cmd.direction;
                            done_d  = 1'b1;
                        end else begin
                            ratio_d = '0;
                            dead_d  = '0;
                        end
                    end
                end
                GEN_DEAD: begin
                    // Dead-time always runs to completion, then takes whatever is requested now.
                    if (boundary) begin
                        if (dead_q == DEAD_LAST) begin
                            ratio_d = cmd.ratio;
                            dir_d   = cmd.direction;
                            done_d  = 1'b1;
                        end else begin
                            dead_d = dead_q + DC_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ratio_q <= '0;
            dir_q   <= 1'b0;
            dead_q  <= '0;
            done_q  <= 1'b0;
            sig_q   <= 1'b0;
        end else begin
            ratio_q <= ratio_d;
            dir_q   <= dir_d;
            dead_q  <= dead_d;
            done_q  <= done_d;
            sig_q   <= sig_d;
        end
    end

    assign pwm_done   = done_q;
    assign pwm_signal = sig_q;
    assign dir_out    = dir_q;
    assign gen_state  = state_q;

endmodule
